// File: rtl/crack_scheduler.sv
// Keyspace scheduler: hands fixed-size key chunks to the lowest idle cracker core,
// latches the first reported hit and aborts all cores, or reports exhaustion.
module crack_scheduler #(
  parameter int NUM_CRACKERS = 4,
  parameter int KEY_WIDTH    = 32,
  parameter int CHUNK_LOG2   = 16,
  parameter int IDX_WIDTH    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_CRACKERS-1:0]         cracker_ready,
  input  logic [NUM_CRACKERS-1:0]         cracker_found,
  input  logic [NUM_CRACKERS*KEY_WIDTH-1:0] cracker_key,
  output logic [NUM_CRACKERS-1:0]         assign_valid,
  output logic [KEY_WIDTH-1:0]            assign_base,
  output logic                            kill,
  output logic                            busy,
  output logic                            done,
  output logic                            found,
  output logic [KEY_WIDTH-1:0]            found_key,
  output logic [IDX_WIDTH-1:0]            found_idx
);

  localparam int CNT_W = KEY_WIDTH - CHUNK_LOG2 + 1;
  // One extra counter bit so "all chunks issued" is representable.
  localparam logic [CNT_W-1:0]     TOTAL = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [KEY_WIDTH-1:0] CHUNK = KEY_WIDTH'(1) << CHUNK_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_d;
  logic [KEY_WIDTH-1:0]    next_base;
  logic [CNT_W-1:0]        chunks_issued;
  logic                    kill_d, clear, dispatch, latch_hit;
  logic [NUM_CRACKERS-1:0] ready_low;
  logic [IDX_WIDTH-1:0]    hit_idx;
  logic [KEY_WIDTH-1:0]    hit_key;

  assign ready_low   = cracker_ready & (~cracker_ready + NUM_CRACKERS'(1));
  assign assign_base = next_base;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  // Lowest-index hit wins; scan downward so the lowest set bit is assigned last.
  always_comb begin
    hit_idx = '0;
    hit_key = '0;
    for (int i = NUM_CRACKERS - 1; i >= 0; i--) begin
      if (cracker_found[i]) begin
        hit_idx = IDX_WIDTH'(i);
        hit_key = cracker_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    kill_d       = 1'b0;
    clear        = 1'b0;
    dispatch     = 1'b0;
    latch_hit    = 1'b0;
    assign_valid = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          kill_d  = 1'b1;
          state_d = IDLE;
        end else if (|cracker_found) begin
          kill_d    = 1'b1;
          latch_hit = 1'b1;
          state_d   = DONE;
        end else if ((chunks_issued == TOTAL) && (&cracker_ready)) begin
          state_d = DONE;
        end else if ((chunks_issued != TOTAL) && (|cracker_ready)) begin
          assign_valid = ready_low;
          dispatch     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_base     <= '0;
      chunks_issued <= '0;
      kill          <= 1'b0;
      found         <= 1'b0;
      found_key     <= '0;
      found_idx     <= '0;
    end else begin
      kill <= kill_d;
      if (clear) begin
        next_base     <= '0;
        chunks_issued <= '0;
        found         <= 1'b0;
        found_key     <= '0;
        found_idx     <= '0;
      end
      if (dispatch) begin
        next_base     <= next_base + CHUNK;
        chunks_issued <= chunks_issued + CNT_W'(1);
      end
      if (latch_hit) begin
        found     <= 1'b1;
        found_key <= hit_key;
        found_idx <= hit_idx;
      end
    end
  end

endmodule
